med_filter: RTL and testbench



---
 rtl/med_filter_if.sv | 13 +
 rtl/med_filter.sv | 67 ++++++
 tb/tb_med_filter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/med_filter_if.sv
// Control and sample bus between the median sequencer (master) and the
// nine-stage median datapath (slave).
interface med_filter_if #(
  parameter int WIDTH = 8
);
  logic             BYP;
  logic             DSI;
  logic [WIDTH-1:0] DI;
  logic [WIDTH-1:0] DO;

  modport master (output BYP, output DSI, output DI, input DO);
  modport slave  (input BYP, input DSI, input DI, output DO);
endinterface

// File: rtl/med_filter.sv
// Nine-stage register ring with one compare-exchange cell on the last two
// stages; under the external median sequence, the median settles in the tail.
module med_filter #(
  parameter int WIDTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  med_filter_if.slave bus
);

  localparam int STAGES = 9;
  localparam int TAIL   = STAGES - 1;
  localparam int PRE    = STAGES - 2;

  logic [WIDTH-1:0] stage_r [STAGES];
  logic [WIDTH-1:0] max_s;
  logic [WIDTH-1:0] min_s;
  logic [WIDTH-1:0] head_s;
  logic [WIDTH-1:0] tail_s;

  function automatic logic [WIDTH-1:0] cx_max(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [WIDTH-1:0] cx_min(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return (a > b) ? b : a;
  endfunction

  // Compare-exchange on the last two stages and head/tail source selection.
  always_comb begin
    max_s  = cx_max(stage_r[PRE], stage_r[TAIL]);
    min_s  = cx_min(stage_r[PRE], stage_r[TAIL]);
    head_s = {WIDTH{1'b0}};
    tail_s = {WIDTH{1'b0}};
    if (bus.DSI) begin
      head_s = bus.DI;
    end else begin
      head_s = min_s;
    end
    if (bus.BYP) begin
      tail_s = stage_r[PRE];
    end else begin
      // Max-retain: the larger value stays at the tail, the smaller recirculates.
      tail_s = max_s;
    end
  end

  // Ring update; reset clears every stage and overrides both control bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_r[0] <= head_s;
      for (int k = 1; k < TAIL; k++) begin
        stage_r[k] <= stage_r[k-1];
      end
      stage_r[TAIL] <= tail_s;
    end
  end

  assign bus.DO = stage_r[TAIL];

endmodule

// File: tb/tb_med_filter.sv
// Directed and random-regression bench for med_filter.
module tb_med_filter;

  logic CLK;
  logic RST;
  int   checks;
  int   failures;

  med_filter_if #(.WIDTH(8)) bus ();

  med_filter #(.WIDTH(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controls; returns 1 time unit after the rising edge.
  task automatic step(input logic dsi, input logic byp, input logic [7:0] di);
    bus.DSI = dsi;
    bus.BYP = byp;
    bus.DI  = di;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_median(input logic [7:0] s [9]);
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, s[k]);
    for (int i = 8; i >= 5; i--) begin
      repeat (i)     step(1'b0, 1'b0, 8'd0);
      repeat (9 - i) step(1'b1, 1'b1, 8'd0);
    end
    repeat (4) step(1'b0, 1'b0, 8'd0);
  endtask

  function automatic int sw_median(input logic [7:0] s [9]);
    int a [9];
    int t;
    for (int k = 0; k < 9; k++) a[k] = int'(s[k]);
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  initial begin
    logic [7:0] s [9];
    checks   = 0;
    failures = 0;
    RST      = 1'b0;
    bus.DSI  = 1'b1;
    bus.BYP  = 1'b1;
    bus.DI   = 8'd0;

    // Put junk in the ring first so reset has something to clear.
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, 8'(8'hA5 + k));
    RST = 1'b1;
    step(1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 8'hC3);
    RST = 1'b0;
    check("reset_do", int'(bus.DO), 0);
    for (int k = 0; k < 9; k++) check($sformatf("reset_r%0d", k), int'(dut.stage_r[k]), 0);

    // Plain shift: sample at edge n reaches DO after edge n+8.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 8'(k));
      check($sformatf("shift_pre%0d", k), int'(bus.DO), 0);
    end
    step(1'b1, 1'b1, 8'd9);
    check("shift_do1", int'(bus.DO), 1);
    step(1'b1, 1'b1, 8'd10);
    check("shift_do2", int'(bus.DO), 2);
    step(1'b1, 1'b1, 8'd11);
    check("shift_do3", int'(bus.DO), 3);

    // Compare cell: after load R8=s0=50, R7=s1=200, R6=s2=30.
    s = '{8'd50, 8'd200, 8'd30, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    for (int k = 0; k < 9; k++) step(1'b1, 1'b1, s[k]);
    check("load_r8", int'(bus.DO), 50);
    check("load_r7", int'(dut.stage_r[7]), 200);
    step(1'b0, 1'b0, 8'd0);
    check("cx_max_r8", int'(bus.DO), 200);
    check("cx_min_r0", int'(dut.stage_r[0]), 50);
    check("cx_shift_r1", int'(dut.stage_r[1]), 9);
    // Illegal combo: min(R7=30, R8=200) recirculates, tail shifts R7.
    step(1'b0, 1'b1, 8'd0);
    check("illegal_r0", int'(dut.stage_r[0]), 30);
    check("illegal_r8", int'(bus.DO), 30);

    // Median, ordered and reversed.
    s = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
    run_median(s);
    check("med_ordered", int'(bus.DO), 50);
    s = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10};
    run_median(s);
    check("med_reversed", int'(bus.DO), 50);

    // Duplicates and extremes, then hold.
    s = '{8'd0, 8'd255, 8'd255, 8'd7, 8'd7, 8'd7, 8'd128, 8'd0, 8'd255};
    run_median(s);
    check("med_dups", int'(bus.DO), 7);
    step(1'b0, 1'b0, 8'd0);
    check("med_hold1", int'(bus.DO), 7);
    step(1'b0, 1'b0, 8'd0);
    check("med_hold2", int'(bus.DO), 7);

    // All-equal extremes.
    s = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
    run_median(s);
    check("med_all255", int'(bus.DO), 255);

    // Reset mid-sequence aborts; a fresh run afterwards is still exact.
    s = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    for (int k = 0; k < 5; k++) step(1'b1, 1'b1, s[k]);
    RST = 1'b1;
    step(1'b0, 1'b0, 8'd77);
    RST = 1'b0;
    check("mid_reset_do", int'(bus.DO), 0);
    check("mid_reset_r0", int'(dut.stage_r[0]), 0);
    s = '{8'd33, 8'd1, 8'd250, 8'd99, 8'd12, 8'd180, 8'd64, 8'd64, 8'd3};
    run_median(s);
    check("med_after_reset", int'(bus.DO), 64);

    // Random back-to-back regression, no reset between runs.
    for (int r = 0; r < 1000; r++) begin
      for (int k = 0; k < 9; k++) s[k] = 8'($urandom_range(0, 255));
      run_median(s);
      check($sformatf("rand_%0d", r), int'(bus.DO), sw_median(s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
